// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator encodings and FSM states for the calculator
package calc_pkg;

  localparam int CALC_DATA_W     = 16;
  localparam int CALC_MAX_DIGITS = 4;
  localparam int CALC_MAX_VALUE  = 9999;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_MUL = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    COMPUTE = 3'd3,
    RESULT  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_controller_key_event.sv
// rtl/calc_controller_key_event.sv - keypad synchronizer, press-edge detect and keycode capture
module key_event (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keycode,
  input  logic       keypressed,
  output logic       key_valid,
  output logic [3:0] key
);

  logic       kp_meta_q, kp_meta_d;
  logic       kp_sync_q, kp_sync_d;
  logic       kp_prev_q, kp_prev_d;
  logic [3:0] code_meta_q, code_meta_d;
  logic [3:0] code_sync_q, code_sync_d;
  logic       valid_q, valid_d;
  logic [3:0] key_q, key_d;

  // Two-flop synchronizers; a single pulse on the synchronized rising edge only
  always_comb begin
    kp_meta_d   = keypressed;
    kp_sync_d   = kp_meta_q;
    kp_prev_d   = kp_sync_q;
    code_meta_d = keycode;
    code_sync_d = code_meta_q;
    valid_d     = kp_sync_q & ~kp_prev_q;
    key_d       = valid_d ? code_sync_q : key_q;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_meta_q   <= 1'b0;
      kp_sync_q   <= 1'b0;
      kp_prev_q   <= 1'b0;
      code_meta_q <= 4'd0;
      code_sync_q <= 4'd0;
      valid_q     <= 1'b0;
      key_q       <= 4'd0;
    end else begin
      kp_meta_q   <= kp_meta_d;
      kp_sync_q   <= kp_sync_d;
      kp_prev_q   <= kp_prev_d;
      code_meta_q <= code_meta_d;
      code_sync_q <= code_sync_d;
      valid_q     <= valid_d;
      key_q       <= key_d;
    end
  end

  assign key_valid = valid_q;
  assign key       = key_q;

endmodule

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - keypad calculator sequencer with operand registers and shift-add multiplier
module calc_controller
  import calc_pkg::*;
#(
  parameter int DATA_W     = CALC_DATA_W,
  parameter int MAX_DIGITS = CALC_MAX_DIGITS,
  parameter int MAX_VALUE  = CALC_MAX_VALUE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        keycode,
  input  logic              keypressed,
  output logic [DATA_W-1:0] display_value,
  output logic [1:0]        op_code,
  output logic              busy,
  output logic              error,
  output logic [2:0]        state_dbg
);

  localparam int                MC_W    = $clog2(DATA_W);
  localparam logic [MC_W-1:0]   MC_LAST = MC_W'(DATA_W - 1);
  localparam logic [2:0]        MAX_CNT = 3'(MAX_DIGITS);
  localparam logic [DATA_W-1:0] TEN     = DATA_W'(10);
  localparam logic [2*DATA_W-1:0] MAX_RES = (2*DATA_W)'(MAX_VALUE);

  logic              ev;
  logic [3:0]        key;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_a_q, acc_a_d;
  logic [DATA_W-1:0] acc_b_q, acc_b_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [2:0]        count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        next_op_q, next_op_d;
  logic              chain_q, chain_d;
  logic [2*DATA_W:0] prod_q, prod_d;
  logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;

  logic [DATA_W:0]     mul_upper;
  logic [2*DATA_W:0]   prod_step;
  logic [2*DATA_W-1:0] result;
  logic                result_bad;
  logic                done;

  key_event u_key_event (
    .clk       (clock),
    .rst       (reset),
    .keycode   (keycode),
    .keypressed(keypressed),
    .key_valid (ev),
    .key       (key)
  );

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] acc, input logic [3:0] d);
    return acc * TEN + {{(DATA_W-4){1'b0}}, d};
  endfunction

  // One shift-add multiplier step (multiplier B sits in the low half) and the candidate result
  always_comb begin
    mul_upper = prod_q[2*DATA_W:DATA_W] + (prod_q[0] ? {1'b0, acc_a_q} : '0);
    prod_step = {mul_upper, prod_q[DATA_W-1:0]} >> 1;
    case (op_q)
      OP_ADD:  result = (2*DATA_W)'({1'b0, acc_a_q} + {1'b0, acc_b_q});
      OP_SUB:  result = (2*DATA_W)'(acc_a_q - acc_b_q);
      OP_MUL:  result = prod_step[2*DATA_W-1:0];
      default: result = '0;
    endcase
    result_bad = ((op_q == OP_SUB) && (acc_b_q > acc_a_q)) || (result > MAX_RES);
  end

  // Next-state and register updates; clear takes priority over everything, including completion
  always_comb begin
    state_d   = state_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    disp_d    = disp_q;
    count_d   = count_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    chain_d   = chain_q;
    prod_d    = prod_q;
    mul_cnt_d = mul_cnt_q;
    done      = 1'b0;

    if (ev && key == KEY_CLR) begin
      state_d   = ENTER_A;
      acc_a_d   = '0;
      acc_b_d   = '0;
      disp_d    = '0;
      count_d   = '0;
      op_d      = OP_NONE;
      next_op_d = OP_NONE;
      chain_d   = 1'b0;
      mul_cnt_d = '0;
    end else begin
      case (state_q)
        ENTER_A: if (ev) begin
          if (is_digit(key)) begin
            if (count_q < MAX_CNT) begin
              acc_a_d = shift_in(acc_a_q, key);
              disp_d  = acc_a_d;
              count_d = count_q + 3'd1;
            end
          end else if (is_op(key)) begin
            op_d    = key_to_op(key);
            state_d = OP_WAIT;
          end
        end
        OP_WAIT: if (ev) begin
          if (is_digit(key)) begin
            acc_b_d = {{(DATA_W-4){1'b0}}, key};
            disp_d  = acc_b_d;
            count_d = 3'd1;
            state_d = ENTER_B;
          end else if (is_op(key)) begin
            op_d = key_to_op(key);
          end
        end
        ENTER_B: if (ev) begin
          if (is_digit(key)) begin
            if (count_q < MAX_CNT) begin
              acc_b_d = shift_in(acc_b_q, key);
              disp_d  = acc_b_d;
              count_d = count_q + 3'd1;
            end
          end else if (key == KEY_EQ || is_op(key)) begin
            chain_d   = is_op(key);
            next_op_d = key_to_op(key);
            prod_d    = {{(DATA_W+1){1'b0}}, acc_b_q};
            mul_cnt_d = '0;
            state_d   = COMPUTE;
          end
        end
        COMPUTE: begin
          if (op_q == OP_MUL) begin
            prod_d    = prod_step;
            mul_cnt_d = mul_cnt_q + 1'b1;
            done      = (mul_cnt_q == MC_LAST);
          end else begin
            done = 1'b1;
          end
          if (done) begin
            if (result_bad) begin
              disp_d  = '0;
              state_d = ERROR;
            end else begin
              acc_a_d = result[DATA_W-1:0];
              disp_d  = result[DATA_W-1:0];
              acc_b_d = '0;
              count_d = '0;
              op_d    = chain_q ? next_op_q : OP_NONE;
              state_d = chain_q ? OP_WAIT : RESULT;
            end
          end
        end
        RESULT: if (ev) begin
          if (is_digit(key)) begin
            acc_a_d = {{(DATA_W-4){1'b0}}, key};
            disp_d  = acc_a_d;
            count_d = 3'd1;
            state_d = ENTER_A;
          end else if (is_op(key)) begin
            op_d    = key_to_op(key);
            state_d = OP_WAIT;
          end
        end
        ERROR:   ;
        default: state_d = ENTER_A;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ENTER_A;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      disp_q    <= '0;
      count_q   <= '0;
      op_q      <= OP_NONE;
      next_op_q <= OP_NONE;
      chain_q   <= 1'b0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      disp_q    <= disp_d;
      count_q   <= count_d;
      op_q      <= op_d;
      next_op_q <= next_op_d;
      chain_q   <= chain_d;
      prod_q    <= prod_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign display_value = disp_q;
  assign op_code       = op_q;
  assign busy          = (state_q == COMPUTE);
  assign error         = (state_q == ERROR);
  assign state_dbg     = state_q;

endmodule
